// File: rtl/seg_display_arbiter_if.sv
// Source-side bus of the seven-segment display arbiter: requests and data in, grant and display value out.
// When SEG_ARB_LOCK_EN is defined the bus also carries i_lock.
interface seg_display_arbiter_if;
  logic [3:0]   i_req;
  logic [127:0] i_src_data;
`ifdef SEG_ARB_LOCK_EN
  logic         i_lock;
`endif
  logic [3:0]   o_grant;
  logic [31:0]  o_disp_data;
  logic         o_switch;

`ifdef SEG_ARB_LOCK_EN
  modport master (output i_req, i_src_data, i_lock, input  o_grant, o_disp_data, o_switch);
  modport slave  (input  i_req, i_src_data, i_lock, output o_grant, o_disp_data, o_switch);
`else
  modport master (output i_req, i_src_data, input  o_grant, o_disp_data, o_switch);
  modport slave  (input  i_req, i_src_data, output o_grant, o_disp_data, o_switch);
`endif
endinterface

// File: rtl/seg_display_arbiter.sv
// Time-sliced round-robin arbiter sharing one 32-bit seven-segment display among four sources.
// Optional feature macro SEG_ARB_LOCK_EN adds i_lock, which freezes the dwell count of the current grant.
module seg_display_arbiter #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26,
  parameter logic [31:0] IDLE_PATTERN = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  seg_display_arbiter_if.slave  io_bus
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_grant, w_grant_nxt;
  logic [31:0]      r_disp, w_disp_nxt;
  logic             r_switch, w_switch_nxt;

  logic [1:0]       w_arb_start;
  logic             w_found;
  logic [1:0]       w_win;
  logic [31:0]      w_win_data;
  logic [31:0]      w_cur_data;
  logic             w_lock;
  logic             w_expire;
  logic             w_drop;

  // First requester at or after 'start', wrapping mod 4; the nearest offset is written last and wins.
  function automatic logic [2:0] f_arbitrate(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    f_arbitrate = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) f_arbitrate = {1'b1, idx};
    end
  endfunction

`ifdef SEG_ARB_LOCK_EN
  assign w_lock = io_bus.i_lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_arb_start        = (r_state == S_HOLD) ? r_idx + 2'd1 : r_ptr;
  assign {w_found, w_win}   = f_arbitrate(io_bus.i_req, w_arb_start);
  assign w_win_data         = io_bus.i_src_data[{w_win, 5'd0} +: 32];
  assign w_cur_data         = io_bus.i_src_data[{r_idx, 5'd0} +: 32];
  assign w_expire           = !w_lock && (r_cnt == LP_CNT_LAST);
  assign w_drop             = !io_bus.i_req[r_idx];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = r_grant;
    w_disp_nxt   = r_disp;
    w_switch_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_disp_nxt  = IDLE_PATTERN;
        if (w_found) begin
          w_state_nxt  = S_HOLD;
          w_idx_nxt    = w_win;
          w_cnt_nxt    = '0;
          w_grant_nxt  = 4'b0001 << w_win;
          w_disp_nxt   = w_win_data;
          w_switch_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_expire || w_drop) begin
          w_ptr_nxt = w_arb_start;
          w_cnt_nxt = '0;
          if (w_found) begin
            // A sole requester is simply re-granted for a fresh dwell without a switch pulse.
            w_idx_nxt    = w_win;
            w_grant_nxt  = 4'b0001 << w_win;
            w_disp_nxt   = w_win_data;
            w_switch_nxt = (w_win != r_idx);
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_disp_nxt  = IDLE_PATTERN;
          end
        end else begin
          if (!w_lock) w_cnt_nxt = r_cnt + CNT_W'(1);
          w_disp_nxt = w_cur_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_disp   <= IDLE_PATTERN;
      r_switch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_disp   <= w_disp_nxt;
      r_switch <= w_switch_nxt;
    end
  end

  assign io_bus.o_grant     = r_grant;
  assign io_bus.o_disp_data = r_disp;
  assign io_bus.o_switch    = r_switch;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with DWELL_CYCLES=4 and IDLE_PATTERN=DEADBEEF.
// Directed scenarios plus a randomized run against a reference model; lock scenario only with SEG_ARB_LOCK_EN.
module tb_seg_display_arbiter;

  localparam int          DWELL = 4;
  localparam logic [31:0] IDLE  = 32'hDEAD_BEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .DWELL_CYCLES (DWELL),
    .CNT_W        (3),
    .IDLE_PATTERN (IDLE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner (-1 = idle), rotation start, dwell cycles still owed to the owner.
  int          m_owner;
  int          m_ptr;
  int          m_left;
  logic [3:0]  exp_grant;
  logic [31:0] exp_data;
  logic        exp_switch;

  function automatic int f_winner(input logic [3:0] req, input int from);
    for (int i = 0; i < 4; i++)
      if (req[(from + i) % 4]) return (from + i) % 4;
    return -1;
  endfunction

  function automatic logic f_lock();
`ifdef SEG_ARB_LOCK_EN
    return bus.i_lock;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_owner = -1; m_ptr = 0; m_left = 0;
    exp_grant = '0; exp_data = IDLE; exp_switch = 1'b0;
  endtask

  task automatic m_update(input logic [3:0] req, input logic [127:0] data, input logic lock);
    int w;
    exp_switch = 1'b0;
    if (m_owner < 0) begin
      w = f_winner(req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_left = DWELL; exp_switch = 1'b1;
      end
    end else begin
      if (!lock) m_left--;
      if (m_left == 0 || !req[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        w = f_winner(req, m_ptr);
        if (w < 0) m_owner = -1;
        else begin
          exp_switch = (w != m_owner);
          m_owner = w; m_left = DWELL;
        end
      end
    end
    exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    exp_data  = (m_owner < 0) ? IDLE : data[m_owner*32 +: 32];
  endtask

  // Advance one clock: model consumes the values the DUT samples, outputs are read 1 ns after the edge.
  task automatic step();
    logic [3:0]   r;
    logic [127:0] d;
    logic         l;
    @(posedge clk);
    r = bus.i_req; d = bus.i_src_data; l = f_lock();
    m_update(r, d, l);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.i_req = '0;
`ifdef SEG_ARB_LOCK_EN
    bus.i_lock = 1'b0;
`endif
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.i_req = '0;
    bus.i_src_data = '0;
`ifdef SEG_ARB_LOCK_EN
    bus.i_lock = 1'b0;
`endif
    m_reset();
    #12;
    n_checks++;
    if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {4'b0000, IDLE, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_values: grant=%b data=%h switch=%b, expected 0000 %h 0", bus.o_grant, bus.o_disp_data, bus.o_switch, IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {4'b0000, IDLE, 1'b0}) begin
        n_errors++;
        $display("FAIL idle_after_reset[%0d]: grant=%b data=%h switch=%b, expected 0000 %h 0", i, bus.o_grant, bus.o_disp_data, bus.o_switch, IDLE);
      end
    end
  endtask

  task automatic test_single_grant();
    int n_sw = 0;
    apply_reset();
    bus.i_src_data = {$urandom, $urandom, $urandom, 32'h1234_5678};
    bus.i_req = 4'b0001;
    step();
    n_checks++;
    if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {4'b0001, 32'h1234_5678, 1'b1}) begin
      n_errors++;
      $display("FAIL single_first_grant: grant=%b data=%h switch=%b, expected 0001 12345678 1", bus.o_grant, bus.o_disp_data, bus.o_switch);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      n_sw += int'(bus.o_switch);
      n_checks++;
      if ({bus.o_grant, bus.o_disp_data} !== {4'b0001, 32'h1234_5678}) begin
        n_errors++;
        $display("FAIL single_hold[%0d]: grant=%b data=%h, expected 0001 12345678", i, bus.o_grant, bus.o_disp_data);
      end
    end
    n_checks++;
    if (n_sw !== 0) begin
      n_errors++;
      $display("FAIL single_no_switch: switch pulses=%0d, expected 0", n_sw);
    end
  endtask

  task automatic test_rotation();
    int          ord [4] = '{0, 1, 3, 0};
    logic [3:0]  g;
    logic [31:0] d;
    apply_reset();
    bus.i_src_data = {$urandom, $urandom, $urandom, $urandom};
    bus.i_req = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      step();
      g = 4'(1 << ord[i / 4]);
      d = bus.i_src_data[ord[i / 4]*32 +: 32];
      n_checks++;
      if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {g, d, (i % 4 == 0)}) begin
        n_errors++;
        $display("FAIL rotation[%0d]: grant=%b data=%h switch=%b, expected %b %h %b", i, bus.o_grant, bus.o_disp_data, bus.o_switch, g, d, (i % 4 == 0));
      end
    end
  endtask

  task automatic test_drop();
    apply_reset();
    bus.i_src_data = {$urandom, $urandom, $urandom, $urandom};
    bus.i_req = 4'b1010;
    step();
    n_checks++;
    if ({bus.o_grant, bus.o_switch} !== {4'b0010, 1'b1}) begin
      n_errors++;
      $display("FAIL drop_first_grant: grant=%b switch=%b, expected 0010 1", bus.o_grant, bus.o_switch);
    end
    step();
    bus.i_req = 4'b1000;
    step();
    n_checks++;
    if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {4'b1000, bus.i_src_data[127:96], 1'b1}) begin
      n_errors++;
      $display("FAIL drop_to_src3: grant=%b data=%h switch=%b, expected 1000 %h 1", bus.o_grant, bus.o_disp_data, bus.o_switch, bus.i_src_data[127:96]);
    end
    bus.i_req = 4'b0000;
    step();
    n_checks++;
    if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {4'b0000, IDLE, 1'b0}) begin
      n_errors++;
      $display("FAIL drop_to_idle: grant=%b data=%h switch=%b, expected 0000 %h 0", bus.o_grant, bus.o_disp_data, bus.o_switch, IDLE);
    end
  endtask

  task automatic test_live_data();
    apply_reset();
    bus.i_src_data = {$urandom, $urandom, $urandom, $urandom};
    bus.i_req = 4'b0100;
    step();
    step();
    bus.i_src_data[95:64] = 32'hCAFE_0002;
    step();
    n_checks++;
    if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {4'b0100, 32'hCAFE_0002, 1'b0}) begin
      n_errors++;
      $display("FAIL live_data: grant=%b data=%h switch=%b, expected 0100 cafe0002 0", bus.o_grant, bus.o_disp_data, bus.o_switch);
    end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    bus.i_src_data = {$urandom, $urandom, $urandom, $urandom};
    bus.i_req = 4'b0011;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (bus.o_grant !== 4'b0010) begin
      n_errors++;
      $display("FAIL pre_reset_rotation: grant=%b, expected 0010", bus.o_grant);
    end
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {4'b0000, IDLE, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset: grant=%b data=%h switch=%b, expected 0000 %h 0", bus.o_grant, bus.o_disp_data, bus.o_switch, IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({bus.o_grant, bus.o_switch} !== {4'b0001, 1'b1}) begin
      n_errors++;
      $display("FAIL ptr_after_reset: grant=%b switch=%b, expected 0001 1", bus.o_grant, bus.o_switch);
    end
  endtask

`ifdef SEG_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    bus.i_src_data = {$urandom, $urandom, $urandom, $urandom};
    bus.i_req = 4'b0011;
    step();
    bus.i_lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (bus.o_grant !== 4'b0001) begin
        n_errors++;
        $display("FAIL lock_hold[%0d]: grant=%b, expected 0001", i, bus.o_grant);
      end
    end
    bus.i_lock = 1'b0;
    for (int i = 0; i < DWELL; i++) begin
      step();
      n_checks++;
      if (bus.o_grant !== ((i == DWELL - 1) ? 4'b0010 : 4'b0001)) begin
        n_errors++;
        $display("FAIL lock_release[%0d]: grant=%b, expected %b", i, bus.o_grant, (i == DWELL - 1) ? 4'b0010 : 4'b0001);
      end
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) bus.i_req = 4'($urandom_range(0, 15));
      bus.i_src_data = {$urandom, $urandom, $urandom, $urandom};
`ifdef SEG_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) bus.i_lock = ~bus.i_lock;
`endif
      step();
      n_checks++;
      if ({bus.o_grant, bus.o_disp_data, bus.o_switch} !== {exp_grant, exp_data, exp_switch}) begin
        n_errors++;
        $display("FAIL random[%0d]: grant=%b data=%h switch=%b, expected %b %h %b", i, bus.o_grant, bus.o_disp_data, bus.o_switch, exp_grant, exp_data, exp_switch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rotation();
    test_drop();
    test_live_data();
    test_reset_mid_hold();
`ifdef SEG_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-sliced round-robin arbiter that shares the single 8-digit seven-segment display between up to four data sources (e.g. PC, instruction word, ALU result, debug register). It sits directly upstream of the display driver: it selects one requester at a time, holds it on the display for a fixed dwell period, then rotates to the next active requester. All outputs are registered, so the display driver always sees a glitch-free 32-bit value.

## Interface
- `DWELL_CYCLES`, 50_000_000: cycles a granted source is held (1 s at 50 MHz); must be ≥ 2.
- `CNT_W`, 26: dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.
- `IDLE_PATTERN`, 32'h0000_0000: value driven on `o_disp_data` when nothing is granted.
- `i_clk`  in  1  system clock (50 MHz); single clock domain.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  4  per-source display request; level-sensitive, bit n = source n.
- `i_src_data`  in  128  packed source data; source n occupies bits [32n+31:32n].
- `i_lock`  in  1  freeze current grant (present only with `SEG_ARB_LOCK_EN`).
- `o_grant`  out  4  one-hot grant, or all zero when idle.
- `o_disp_data`  out  32  value for the display driver.
- `o_switch`  out  1  one-cycle pulse in the cycle `o_grant` takes a new non-zero value.

## Operation
- Two-state FSM: IDLE, HOLD. Internal regs: `ptr[1:0]` (round-robin start), `cnt[CNT_W-1:0]`.
- Arbitration function: the first set bit of `i_req` searching `ptr`, `ptr+1`, … mod 4.
- IDLE: `o_grant`=0 and `o_disp_data`=IDLE_PATTERN. If `i_req`≠0, grant the winner, set `cnt`=0, and go to HOLD.
- HOLD, each cycle: `o_disp_data` ← data slice of the granted source, so live updates of that source pass through. `cnt` increments.
- Re-arbitration in HOLD is triggered by either:
  - (a) `cnt == DWELL_CYCLES-1`;
  - (b) the granted source's `i_req` bit is low.
- On re-arbitration:
  - Set `ptr` = granted index + 1 (mod 4), then arbitrate over `i_req`.
  - If the winner differs from the current grant, regrant and pulse `o_switch`.
  - If the winner is the same source (it is the only requester), keep the grant with no `o_switch`; `cnt` restarts at 0.
  - If there is no winner, go to IDLE; `o_disp_data` returns to IDLE_PATTERN in the same edge.
- Data from a newly granted source appears on `o_disp_data` in the same edge as its grant.
- Other requesters never preempt before dwell expiry. No source is starved: the worst-case wait is 3×DWELL_CYCLES.

## Timing
- Reset (async assert, synchronous release on `i_clk`) sets: state IDLE, `ptr`=0, `cnt`=0, `o_grant`=0, `o_disp_data`=IDLE_PATTERN, `o_switch`=0.
- Request to grant latency: 1 cycle. `i_req` sampled at edge k gives `o_grant`/`o_disp_data` valid after edge k.
- Dwell: a grant issued at edge k re-arbitrates at edge k+DWELL_CYCLES.
- Drop detection: a granted request deasserted before edge k causes re-arbitration at edge k.
- `o_switch`: high for exactly the cycle after the edge that changes the grant. It also pulses on the IDLE→HOLD transition.
- If dwell expiry and request drop occur in the same cycle, they are handled identically (one re-arbitration).
- Reset mid-HOLD: all outputs return to reset values immediately, and `ptr` returns to 0.

## Configuration
- Macro `SEG_ARB_LOCK_EN`.
- Defined:
  - Port `i_lock` exists.
  - While `i_lock`=1 in HOLD, `cnt` holds its value and dwell expiry is suppressed.
  - A drop of the granted request still forces re-arbitration.
  - Lock has no effect in IDLE.
  - On `i_lock` release, counting resumes from the held value.
- Not defined: port `i_lock` is absent and rotation is purely dwell/drop driven.

## Test plan
(Use DWELL_CYCLES=4 and IDLE_PATTERN=32'hDEAD_BEEF.)
- Reset → `o_grant`=0, `o_disp_data`=DEADBEEF, `o_switch`=0. After release with `i_req`=0 for 10 cycles, outputs are unchanged.
- `i_req`=4'b0001, source0=32'h1234_5678 → next cycle `o_grant`=0001, `o_disp_data`=12345678, `o_switch` pulses once. The grant holds indefinitely with no further `o_switch`.
- `i_req`=4'b1011 held steady → grant order 0001, 0010, 1000, 0001, each lasting 4 cycles, with `o_switch` at each change.
- Source 1 granted, deasserts its `i_req` at cycle 2 of dwell while `i_req[3]`=1 → next edge `o_grant`=1000. If no requesters remain → `o_grant`=0, `o_disp_data`=DEADBEEF.
- Source 2 granted, source 2 data changes to 32'hCAFE_0002 mid-dwell → `o_disp_data` follows 1 cycle later with the grant unchanged.
- `SEG_ARB_LOCK_EN`: `i_req`=4'b0011, `i_lock`=1 for 20 cycles → `o_grant` stays 0001. After lock release, the remaining dwell completes and the grant moves to 0010. Asserting `i_rst_n`=0 mid-HOLD → immediate reset values.
